// File: rtl/mac_job_ctrl_pkg.sv
// Shared command modes and state encodings for the MAC job sequencer and mac_fsm.
// No logic; the saturating add keeps counter arithmetic identical across users.
package mac_job_ctrl_pkg;

    localparam logic MODE_DATA   = 1'b0;
    localparam logic MODE_WEIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST_W  = 3'd1,
        LOAD_W = 3'd2,
        RST_D  = 3'd3,
        LOAD_D = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6,
        ABORT  = 3'd7
    } state_t;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max);
        return (a + b > max) ? max : a + b;
    endfunction

endpackage

// File: rtl/mac_wdog.sv
// Down-counting watchdog: reloads to all-ones, fires on the last enabled count.
// Expiry is a same-cycle strobe; a load in that cycle suppresses it.
module mac_wdog #(
    parameter int TO_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '1;
        end else if (load) begin
            cnt <= '1;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && !load && (cnt == TO_W'(1));

endmodule

// File: rtl/mac_job_ctrl.sv
// Job sequencer for the MAC array: weight load, data stream, result drain; commands lag acceptance by one cycle.
// Source is throttled by a state-decoded ready; ena low freezes everything and masks ready/valid/done.
module mac_job_ctrl
    import mac_job_ctrl_pkg::*;
#(
    parameter int N    = 2,
    parameter int NN   = N * N,
    parameter int W    = 8,
    parameter int TO_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start_i,
    input  logic         reload_w_i,
    input  logic         abort_i,
    input  logic         in_v_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_rdy_o,
    output logic         data_v_o,
    output logic         data_mode_o,
    output logic         data_rst_addr_o,
    output logic [W-1:0] data_o,
    input  logic [N-1:0] res_wr_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int CW = $clog2(NN + 1);
    localparam int PW = $clog2(N + 1);

    state_t        state, nxt;
    logic          w_loaded, rst_pend;
    logic          rdy_q, data_v_q, done_q;
    logic [CW-1:0] wcnt, rcnt, rcnt_nxt;
    logic [PW-1:0] pc;
    logic          accept, last_word, drained;
    logic          wd_load, wd_en, wd_exp;

    // Flopped flags masked by ena so a frozen cycle never hands over a word or a pulse.
    assign in_rdy_o = rdy_q & ena;
    assign data_v_o = data_v_q & ena;
    assign done_o   = done_q & ena;

    assign accept    = in_v_i & in_rdy_o;
    assign last_word = accept && (wcnt == CW'(NN - 1));

    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) begin
            pc = pc + PW'(res_wr_i[i]);
        end
    end

    assign rcnt_nxt = CW'(sat_add(32'(rcnt), 32'(pc), NN));
    assign drained  = (state == DRAIN) && (rcnt_nxt == CW'(NN));
    assign wd_load  = ena && (state != DRAIN || pc != '0);
    assign wd_en    = ena && (state == DRAIN);

    mac_wdog #(.TO_W(TO_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wd_load),
        .en      (wd_en),
        .expired (wd_exp)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_i) nxt = (reload_w_i || !w_loaded) ? RST_W : RST_D;
            RST_W:   nxt = LOAD_W;
            LOAD_W:  if (last_word) nxt = RST_D;
            RST_D:   nxt = LOAD_D;
            LOAD_D:  if (last_word) nxt = DRAIN;
            DRAIN:   if (drained) nxt = DONE; else if (wd_exp) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort_i && state != IDLE) nxt = ABORT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            w_loaded        <= 1'b0;
            rst_pend        <= 1'b0;
            rdy_q           <= 1'b0;
            data_v_q        <= 1'b0;
            data_rst_addr_o <= 1'b0;
            data_mode_o     <= MODE_DATA;
            data_o          <= '0;
            busy_o          <= 1'b0;
            done_q          <= 1'b0;
            err_o           <= 1'b0;
            wcnt            <= '0;
            rcnt            <= '0;
        end else if (ena) begin
            state    <= nxt;
            rdy_q    <= (nxt == LOAD_W) || (nxt == LOAD_D);
            busy_o   <= (nxt != IDLE);
            done_q   <= (nxt == DONE);
            rst_pend <= 1'b0;

            data_v_q        <= 1'b0;
            data_rst_addr_o <= 1'b0;
            data_mode_o     <= MODE_DATA;
            // The last weight word owns the RST_D command slot, so that address reset is sent one cycle later.
            if (nxt == ABORT || nxt == RST_W || (nxt == RST_D && !last_word)) begin
                data_v_q        <= 1'b1;
                data_rst_addr_o <= 1'b1;
                data_mode_o     <= (nxt == RST_W) ? MODE_WEIGHT : MODE_DATA;
            end else if (accept) begin
                data_v_q    <= 1'b1;
                data_o      <= in_data_i;
                data_mode_o <= (state == LOAD_W) ? MODE_WEIGHT : MODE_DATA;
                rst_pend    <= (nxt == RST_D);
            end else if (rst_pend) begin
                data_v_q        <= 1'b1;
                data_rst_addr_o <= 1'b1;
            end

            if (state == IDLE || state == RST_W || state == RST_D) begin
                wcnt <= '0;
            end else if (accept && wcnt != CW'(NN)) begin
                wcnt <= wcnt + 1'b1;
            end

            if (state == RST_D) begin
                rcnt <= '0;
            end else if (state == LOAD_D || state == DRAIN) begin
                rcnt <= rcnt_nxt;
            end

            if (nxt == ABORT && (state == RST_W || state == LOAD_W)) begin
                w_loaded <= 1'b0;
            end else if (state == LOAD_W && nxt == RST_D) begin
                w_loaded <= 1'b1;
            end

            if (state == IDLE && start_i) begin
                err_o <= 1'b0;
            end else if (state == DRAIN && nxt == IDLE) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
